// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit count display.
`timescale 1ns/1ps
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Active-low anodes: an[0] drives the ones digit, an[1] the tens digit.
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/count_display_if.sv
// Bus between the decade counter (master) and the display block (slave).
`timescale 1ns/1ps
interface count_display_if;
  logic [7:0] count;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       bcd_valid;
  logic       ovf;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output count,
    input  tens, ones, bcd_valid, ovf, seg, an
  );

  modport slave (
    input  count,
    output tens, ones, bcd_valid, ovf, seg, an
  );
endinterface

// File: rtl/count_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes go dark.
`timescale 1ns/1ps
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit.
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Binary count (0-99) to two BCD digits via a sequential double-dabble
// engine, shown on a time-multiplexed common-anode seven-segment display.
`timescale 1ns/1ps
module count_display
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  count_display_if.slave   bus
);

  localparam int unsigned    RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);

  state_e        state_q, state_d;
  logic [7:0]    last_val_q, last_val_d;
  logic [7:0]    bin_q, bin_d;
  logic [7:0]    bcd_q, bcd_d;
  logic [2:0]    iter_q, iter_d;
  logic          force_conv_q, force_conv_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          digit_sel_q, digit_sel_d;

  logic [7:0]    bcd_adj;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_o;
  logic [1:0]    an_o;

  // All state registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_val_q   <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      force_conv_q <= 1'b1;
      tens_q       <= '0;
      ones_q       <= '0;
      bcd_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      ref_cnt_q    <= '0;
      digit_sel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_val_q   <= last_val_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      force_conv_q <= force_conv_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      bcd_valid_q  <= bcd_valid_d;
      ovf_q        <= ovf_d;
      ref_cnt_q    <= ref_cnt_d;
      digit_sel_q  <= digit_sel_d;
    end
  end

  // Conversion FSM: sample on change, eight add-3/shift steps, then publish.
  always_comb begin
    state_d      = state_q;
    last_val_d   = last_val_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    force_conv_d = force_conv_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    bcd_valid_d  = bcd_valid_q;
    ovf_d        = ovf_q;
    bcd_adj      = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (force_conv_q || (bus.count != last_val_q)) begin
          last_val_d   = bus.count;
          bin_d        = bus.count;
          bcd_d        = '0;
          iter_d       = '0;
          force_conv_d = 1'b0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        bcd_d  = {bcd_adj[6:0], bin_q[7]};
        bin_d  = {bin_q[6:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        // Out-of-range values keep the last good digits; only the flag moves.
        if (last_val_q > 8'd99) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d  = 1'b0;
          tens_d = bcd_q[7:4];
          ones_d = bcd_q[3:0];
        end
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit-slot timer, independent of the conversion FSM.
  always_comb begin
    ref_cnt_d   = ref_cnt_q + RW'(1);
    digit_sel_d = digit_sel_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d   = '0;
      digit_sel_d = ~digit_sel_q;
    end
  end

  assign digit = digit_sel_q ? tens_q : ones_q;

  seg7_decode u_decode (
    .digit (digit),
    .seg   (seg_dec)
  );

  // Display drive from registered state: dark until valid, dashes on overflow.
  always_comb begin
    an_o  = AN_OFF;
    seg_o = SEG_OFF;
    if (bcd_valid_q) begin
      an_o = digit_sel_q ? AN_TENS : AN_ONES;
      if (ovf_q) begin
        seg_o = SEG_DASH;
      end else if (digit_sel_q && BLANK_LZ && (tens_q == 4'd0)) begin
        an_o = AN_OFF;
      end else begin
        seg_o = seg_dec;
      end
    end
  end

  assign bus.tens      = tens_q;
  assign bus.ones      = ones_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.seg       = seg_o;
  assign bus.an        = an_o;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with a due-cycle scoreboard of conversions
// and a per-cycle check of digits, flags and the multiplexed display.
`timescale 1ns/1ps
module tb_count_display;

  localparam int unsigned RDIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  count_display_if bus ();

  count_display #(
    .REFRESH_DIV (RDIV),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int       due;
    logic [3:0] tens;
    logic [3:0] ones;
    logic     ovf;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int k = 0;

  logic [3:0] m_tens = 4'd0;
  logic [3:0] m_ones = 4'd0;
  logic       m_ovf = 1'b0;
  logic       m_valid = 1'b0;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, k);
    end
  endtask

  // Expect the result of a conversion whose sampling edge is the next edge.
  task automatic start(input int t, input int o, input logic v);
    exp_t e;
    e.due  = k + 10;
    e.tens = 4'(t);
    e.ones = 4'(o);
    e.ovf  = v;
    sb.push_back(e);
  endtask

  task automatic push_due(input int due, input int t, input int o, input logic v);
    exp_t e;
    e.due  = due;
    e.tens = 4'(t);
    e.ones = 4'(o);
    e.ovf  = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t       e;
    logic       sel;
    logic [1:0] an_e;
    logic [6:0] seg_e;
    @(posedge clk);
    #1;
    if (reset) begin
      k = 0;
      sb.delete();
      m_tens  = 4'd0;
      m_ones  = 4'd0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      k++;
    end
    while (sb.size() > 0 && sb[0].due == k) begin
      e = sb.pop_front();
      m_valid = 1'b1;
      m_ovf   = e.ovf;
      if (!e.ovf) begin
        m_tens = e.tens;
        m_ones = e.ones;
      end
    end
    sel   = ((k / RDIV) % 2) == 1;
    an_e  = 2'b11;
    seg_e = 7'h7F;
    if (m_valid) begin
      an_e = sel ? 2'b01 : 2'b10;
      if (m_ovf) seg_e = 7'h3F;
      else if (sel && m_tens == 4'd0) an_e = 2'b11;
      else seg_e = dec(sel ? m_tens : m_ones);
    end
    check("tens", {4'd0, bus.tens}, {4'd0, m_tens});
    check("ones", {4'd0, bus.ones}, {4'd0, m_ones});
    check("bcd_valid", {7'd0, bus.bcd_valid}, {7'd0, m_valid});
    check("ovf", {7'd0, bus.ovf}, {7'd0, m_ovf});
    check("an", {6'd0, bus.an}, {6'd0, an_e});
    if (an_e != 2'b11) check("seg", {1'b0, bus.seg}, {1'b0, seg_e});
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  initial begin
    bus.count = 8'd0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    start(0, 0, 1'b0);
    run_to(12);

    bus.count = 8'd42;  start(4, 2, 1'b0); run_to(30);
    bus.count = 8'd98;  start(9, 8, 1'b0); run_to(42);
    bus.count = 8'd99;  start(9, 9, 1'b0); run_to(54);
    bus.count = 8'd0;   start(0, 0, 1'b0); run_to(66);
    bus.count = 8'd35;  start(3, 5, 1'b0); run_to(78);
    bus.count = 8'd150; start(0, 0, 1'b1); run_to(92);
    bus.count = 8'd7;   start(0, 7, 1'b0); run_to(104);

    // Change lands mid-conversion: first result is 12, then a reconversion.
    bus.count = 8'd12;  start(1, 2, 1'b0);
    run_to(106);
    bus.count = 8'd57;  push_due(124, 5, 7, 1'b0);
    run_to(126);

    // Abort with reset after four shift steps, then convert afresh.
    bus.count = 8'd63;  start(6, 3, 1'b0);
    run_to(131);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    start(6, 3, 1'b0);
    run_to(16);

    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
